// File: rtl/int2_array_unpacker.sv
// int2_array_unpacker
// Accepts a two-element integer array on a sync/notify input port and emits the
// elements one at a time on a sync/notify output port. It optionally reverses
// the element order and optionally drops zero-valued elements. A free-running
// count of emitted elements is provided for debug.
module int2_array_unpacker #(
  parameter bit REVERSE   = 1'b0,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0][31:0] a_in,
  input  logic             a_in_sync,
  output logic             a_in_notify,
  output logic [31:0]      i_out,
  input  logic             i_out_sync,
  output logic             i_out_notify,
  output logic [31:0]      elem_count
);

  typedef enum logic [1:0] {
    READ  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0][31:0] arr_q, arr_d;
  logic [31:0]      out_q, out_d;
  logic [31:0]      count_q, count_d;

  // Emission order of the array on the input port and of the latched copy.
  logic [31:0] in_first, in_second, held_second;

  assign in_first    = REVERSE ? a_in[1]  : a_in[0];
  assign in_second   = REVERSE ? a_in[0]  : a_in[1];
  assign held_second = REVERSE ? arr_q[0] : arr_q[1];

  // Both notifies are decoded from the state, so they can never be 1 together.
  assign a_in_notify  = (state_q == READ);
  assign i_out_notify = (state_q != READ);
  assign i_out        = out_q;
  assign elem_count   = count_q;

  // Next-state logic: accept an array in READ, then hand out its elements.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned; this prevents latch inference.
    state_d = state_q;
    arr_d   = arr_q;
    out_d   = out_q;
    count_d = count_q;
    unique case (state_q)
      READ: begin
        if (a_in_sync) begin
          arr_d = a_in;
          if (SKIP_ZERO && (in_first == 32'd0)) begin
            // A zero first element is skipped. If both elements are zero,
            // nothing is emitted and the block stays ready.
            if (in_second != 32'd0) begin
              out_d   = in_second;
              state_d = SEND1;
            end
          end else begin
            out_d   = in_first;
            state_d = SEND0;
          end
        end
      end
      SEND0: begin
        if (i_out_sync) begin
          count_d = count_q + 32'd1;
          if (SKIP_ZERO && (held_second == 32'd0)) begin
            state_d = READ;
          end else begin
            out_d   = held_second;
            state_d = SEND1;
          end
        end
      end
      SEND1: begin
        if (i_out_sync) begin
          count_d = count_q + 32'd1;
          state_d = READ;
        end
      end
      default: state_d = READ;
    endcase
  end

  // State, array, output and count registers with a synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array register is small and has a defined reset value, so it is reset explicitly like the other state.
      state_q <= READ;
      arr_q   <= '0;
      out_q   <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      state_q <= state_d;
      arr_q   <= arr_d;
      out_q   <= out_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_int2_array_unpacker.sv
// Self-checking bench for int2_array_unpacker. Three instances share one set of
// inputs: default, REVERSE=1 and SKIP_ZERO=1. A queue-based model predicts each
// instance's outputs, and the model is checked on every cycle. Directed phases
// add literal expectations.
module tb_int2_array_unpacker;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0][31:0] a_in = '0;
  logic             a_in_sync = 1'b0;
  logic             i_out_sync = 1'b0;

  logic        o_an [3];
  logic [31:0] o_i  [3];
  logic        o_in [3];
  logic [31:0] o_c  [3];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  int2_array_unpacker #(.REVERSE(1'b0), .SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_in_sync(a_in_sync), .a_in_notify(o_an[0]),
    .i_out(o_i[0]), .i_out_sync(i_out_sync), .i_out_notify(o_in[0]), .elem_count(o_c[0]));
  int2_array_unpacker #(.REVERSE(1'b1), .SKIP_ZERO(1'b0)) dut1 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_in_sync(a_in_sync), .a_in_notify(o_an[1]),
    .i_out(o_i[1]), .i_out_sync(i_out_sync), .i_out_notify(o_in[1]), .elem_count(o_c[1]));
  int2_array_unpacker #(.REVERSE(1'b0), .SKIP_ZERO(1'b1)) dut2 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_in_sync(a_in_sync), .a_in_notify(o_an[2]),
    .i_out(o_i[2]), .i_out_sync(i_out_sync), .i_out_notify(o_in[2]), .elem_count(o_c[2]));

  // Reference model. An instance is busy while it holds elements still to be
  // emitted, and idle (ready for an array) while its queue is empty.
  bit          m_rev  [3] = '{1'b0, 1'b1, 1'b0};
  bit          m_skip [3] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] mq     [3][$];
  logic [31:0] m_out  [3];
  logic [31:0] m_cnt  [3];
  logic [31:0] e_first, e_second;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mq[k].delete();
        m_out[k] = 32'd0;
        m_cnt[k] = 32'd0;
      end else if (mq[k].size() == 0) begin
        if (a_in_sync) begin
          e_first  = m_rev[k] ? a_in[1] : a_in[0];
          e_second = m_rev[k] ? a_in[0] : a_in[1];
          if (!(m_skip[k] && e_first == 32'd0))  mq[k].push_back(e_first);
          if (!(m_skip[k] && e_second == 32'd0)) mq[k].push_back(e_second);
          if (mq[k].size() != 0) m_out[k] = mq[k][0];
        end
      end else if (i_out_sync) begin
        void'(mq[k].pop_front());
        m_cnt[k] = m_cnt[k] + 32'd1;
        if (mq[k].size() != 0) m_out[k] = mq[k][0];
      end
    end
  end

  // Elements taken from the SKIP_ZERO instance, recorded in emission order.
  logic [31:0] skip_log [$];
  always @(posedge clk) begin
    if (!rst && o_in[2] && i_out_sync) skip_log.push_back(o_i[2]);
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Compare every instance against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("model_i_out[%0d]", k), o_i[k], m_out[k]);
        check($sformatf("model_i_out_notify[%0d]", k), {31'd0, o_in[k]}, {31'd0, mq[k].size() != 0});
        check($sformatf("model_a_in_notify[%0d]", k), {31'd0, o_an[k]}, {31'd0, mq[k].size() == 0});
        check($sformatf("model_elem_count[%0d]", k), o_c[k], m_cnt[k]);
      end
    end
  end

  // Present one array for a single cycle. Returns at the falling edge after acceptance.
  task automatic send(input logic [31:0] e0, input logic [31:0] e1);
    a_in[0]   = e0;
    a_in[1]   = e1;
    a_in_sync = 1'b1;
    @(negedge clk);
    a_in_sync = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(o_an[0] && o_an[1] && o_an[2]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {31'd0, o_an[0] && o_an[1] && o_an[2]}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset, then check the literal reset state.
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_i_out", o_i[0], 32'd0);
    check("rst_i_out_notify", {31'd0, o_in[0]}, 32'd0);
    check("rst_a_in_notify", {31'd0, o_an[0]}, 32'd1);
    check("rst_elem_count", o_c[0], 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic pass-through of '{5, -3}, with the consumer always ready.
    i_out_sync = 1'b1;
    send(32'd5, 32'hFFFF_FFFD);
    check("t1_first", o_i[0], 32'd5);
    check("t1_first_notify", {31'd0, o_in[0]}, 32'd1);
    check("t1_busy", {31'd0, o_an[0]}, 32'd0);
    check("t1_rev_first", o_i[1], 32'hFFFF_FFFD);
    @(negedge clk);
    check("t1_second", o_i[0], 32'hFFFF_FFFD);
    check("t1_rev_second", o_i[1], 32'd5);
    @(negedge clk);
    check("t1_ready_again", {31'd0, o_an[0]}, 32'd1);
    check("t1_count", o_c[0], 32'd2);

    // Backpressure: the consumer stalls for 4 cycles.
    i_out_sync = 1'b0;
    send(32'd5, 32'hFFFF_FFFD);
    for (int i = 0; i < 4; i++) begin
      check("t2_hold_val", o_i[0], 32'd5);
      check("t2_hold_notify", {31'd0, o_in[0]}, 32'd1);
      check("t2_hold_busy", {31'd0, o_an[0]}, 32'd0);
      @(negedge clk);
    end
    i_out_sync = 1'b1;
    @(negedge clk);
    check("t2_second", o_i[0], 32'hFFFF_FFFD);
    check("t2_count_mid", o_c[0], 32'd3);
    @(negedge clk);
    check("t2_count", o_c[0], 32'd4);

    // Reversed emission order on the REVERSE instance.
    wait_idle();
    send(32'd7, 32'd9);
    check("t3_rev_first", o_i[1], 32'd9);
    @(negedge clk);
    check("t3_rev_second", o_i[1], 32'd7);
    @(negedge clk);

    // Zero skipping on the SKIP_ZERO instance.
    do_reset();
    skip_log.delete();
    wait_idle();
    send(32'd0, 32'd4);
    wait_idle();
    send(32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t4_zero_pair_ready", {31'd0, o_an[2]}, 32'd1);
      check("t4_zero_pair_quiet", {31'd0, o_in[2]}, 32'd0);
      @(negedge clk);
    end
    wait_idle();
    send(32'd8, 32'd0);
    wait_idle();
    @(negedge clk);
    check("t4_log_size", skip_log.size(), 32'd2);
    if (skip_log.size() == 2) begin
      check("t4_log0", skip_log[0], 32'd4);
      check("t4_log1", skip_log[1], 32'd8);
    end
    check("t4_count", o_c[2], 32'd2);

    // Reset while an element is pending in SEND0.
    wait_idle();
    i_out_sync = 1'b0;
    send(32'd11, 32'd22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_i_out_notify", {31'd0, o_in[0]}, 32'd0);
    check("t5_a_in_notify", {31'd0, o_an[0]}, 32'd1);
    check("t5_i_out", o_i[0], 32'd0);
    check("t5_count", o_c[0], 32'd0);
    i_out_sync = 1'b1;
    send(32'd33, 32'd44);
    check("t5_first", o_i[0], 32'd33);
    @(negedge clk);
    check("t5_second", o_i[0], 32'd44);

    // Count wrap: preload the count near the top, then send one array.
    wait_idle();
    force dut0.count_q = 32'hFFFF_FFFE;
    m_cnt[0] = 32'hFFFF_FFFE;
    repeat (2) @(negedge clk);
    release dut0.count_q;
    check("t6_preload", o_c[0], 32'hFFFF_FFFE);
    send(32'd1, 32'd2);
    @(negedge clk);
    check("t6_count_max", o_c[0], 32'hFFFF_FFFF);
    @(negedge clk);
    check("t6_count_wrap", o_c[0], 32'd0);

    // Randomized traffic with zeros, stalls and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      a_in[0]    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      a_in[1]    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      a_in_sync  = $urandom_range(0, 1) == 1;
      i_out_sync = $urandom_range(0, 2) != 0;
      rst        = $urandom_range(0, 199) == 0;
      @(negedge clk);
    end
    rst = 1'b0;
    a_in_sync = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
